// File: rtl/prog_instr_mem.sv
// Loadable instruction memory: program words are streamed in while in BOOT, then served as
// registered fetches in RUN. Define IMEM_BOUNDS_EN to also fault fetches past the loaded program.
module prog_instr_mem #(
  parameter int                      INSTR_WIDTH = 9,
  parameter int                      ADDR_WIDTH  = 12,
  parameter int                      PC_WIDTH    = 32,
  parameter string                   INIT_FILE   = "",
  parameter logic [INSTR_WIDTH-1:0]  NOP_WORD    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_en,
  input  logic [ADDR_WIDTH-1:0]  load_addr,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   load_done,
  input  logic                   reload,
  input  logic                   fetch_req,
  input  logic [PC_WIDTH-1:0]    fetch_pc,
  output logic                   fetch_valid,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   fetch_fault,
  output logic                   ready,
  output logic [ADDR_WIDTH:0]    load_hwm
);

  localparam int DEPTH    = 1 << ADDR_WIDTH;
  localparam bit HAS_INIT = (INIT_FILE != "");

  typedef enum logic {ST_BOOT, ST_RUN} state_t;

  localparam state_t                RESET_STATE = HAS_INIT ? ST_RUN : ST_BOOT;
  localparam logic [ADDR_WIDTH:0]   HWM_RESET   = HAS_INIT ? (ADDR_WIDTH+1)'(DEPTH) : '0;

  logic [INSTR_WIDTH-1:0] mem [DEPTH];

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH:0]    load_hwm_q, load_hwm_d;
  logic                   fetch_valid_q, fetch_valid_d;
  logic                   fetch_fault_q, fetch_fault_d;
  logic [INSTR_WIDTH-1:0] instruction_q;

  logic [ADDR_WIDTH-1:0]  pc_idx;
  logic [ADDR_WIDTH:0]    load_end;
  logic                   upper_oob;
  logic                   fetch_oob;
  logic                   fetch_accept;
  logic                   load_we;

  assign pc_idx       = fetch_pc[ADDR_WIDTH-1:0];
  assign upper_oob    = |fetch_pc[PC_WIDTH-1:ADDR_WIDTH];
  assign load_end     = {1'b0, load_addr} + 1'b1;
  assign load_we      = (state_q == ST_BOOT) && load_en;
  // reload takes priority over a same-cycle fetch request
  assign fetch_accept = (state_q == ST_RUN) && fetch_req && !reload;

`ifdef IMEM_BOUNDS_EN
  assign fetch_oob = upper_oob || ({1'b0, pc_idx} >= load_hwm_q);
`else
  assign fetch_oob = upper_oob;
`endif

  always_comb begin
    state_d       = state_q;
    load_hwm_d    = load_hwm_q;
    fetch_valid_d = fetch_accept;
    fetch_fault_d = fetch_accept && fetch_oob;
    case (state_q)
      ST_BOOT: begin
        if (load_we && (load_end > load_hwm_q)) load_hwm_d = load_end;
        if (load_done) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (reload) begin
          state_d    = ST_BOOT;
          load_hwm_d = '0;
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RESET_STATE;
      load_hwm_q    <= HWM_RESET;
      fetch_valid_q <= 1'b0;
      fetch_fault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_hwm_q    <= load_hwm_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_fault_q <= fetch_fault_d;
    end
  end

  // Array is deliberately outside the reset so loaded programs survive a reset.
  always_ff @(posedge clk) begin
    if (load_we) mem[load_addr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instruction_q <= NOP_WORD;
    end else if (fetch_accept) begin
      instruction_q <= fetch_oob ? NOP_WORD : mem[pc_idx];
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign fetch_fault = fetch_fault_q;
  assign instruction = instruction_q;
  assign load_hwm    = load_hwm_q;
  assign ready       = (state_q == ST_RUN);

endmodule
